// File: rtl/ex_branch_resolve_pkg.sv
// Shared encodings for the execute-stage branch resolver: instr_type one-hot
// indices, branch funct3 codes and the redirect FSM state.
package ex_branch_resolve_pkg;

  localparam int TYPE_W      = 8;
  localparam int TYPE_BRANCH = 4;
  localparam int TYPE_JAL    = 5;
  localparam int TYPE_JALR   = 6;

  localparam logic [TYPE_W-1:0] OH_BRANCH = TYPE_W'(1) << TYPE_BRANCH;
  localparam logic [TYPE_W-1:0] OH_JAL    = TYPE_W'(1) << TYPE_JAL;
  localparam logic [TYPE_W-1:0] OH_JALR   = TYPE_W'(1) << TYPE_JALR;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

endpackage

// File: rtl/ex_branch_resolve_cmp.sv
// Branch condition evaluator; purely combinational.
// Reserved funct3 codes (010/011) resolve as not-taken.
module branch_cmp
  import ex_branch_resolve_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_branch_resolve.sv
// Execute-stage branch resolver: result register 1 cycle after fire; mispredicts raise a held redirect + 1-cycle flush.
// Backpressure: stalls decode while a redirect is unacknowledged or the result register is full and not drained.
module ex_branch_resolve
  import ex_branch_resolve_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 D_instr_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      D_PC,
  input  logic [XLEN-1:0]      D_recoverPC,
  input  logic [TYPE_W-1:0]    D_instr_type,
  input  logic [2:0]           D_funct3,
  input  logic [XLEN-1:0]      D_immediate32,
  input  logic                 D_BranchTaken,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  input  logic                 redirect_ack,
  output logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_link,
  output logic                 out_taken,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  state_e               state_q, state_d;
  logic                 redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]      redirect_pc_q, redirect_pc_d;
  logic                 flush_q, flush_d;
  logic                 out_valid_q, out_valid_d;
  logic [XLEN-1:0]      out_pc_q, out_pc_d;
  logic [XLEN-1:0]      out_link_q, out_link_d;
  logic                 out_taken_q, out_taken_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

  logic            is_branch, is_jal, is_jalr;
  logic            br_taken, actual_taken, fire, mispredict;
  logic [XLEN-1:0] jalr_sum, jalr_target, link_pc;

  assign is_branch = |(D_instr_type & OH_BRANCH);
  assign is_jal    = |(D_instr_type & OH_JAL);
  assign is_jalr   = |(D_instr_type & OH_JALR);

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3 (D_funct3),
    .rs1    (rs1_data),
    .rs2    (rs2_data),
    .taken  (br_taken)
  );

  assign jalr_sum    = rs1_data + D_immediate32;
  assign jalr_target = jalr_sum & ~XLEN'(1);
  assign link_pc     = D_PC + XLEN'(4);

  assign in_ready     = (state_q == ST_IDLE) & (~out_valid_q | out_ready);
  assign fire         = in_ready & D_instr_valid;
  assign actual_taken = is_branch ? br_taken : (is_jal | is_jalr);
  // JALR targets are never predicted at decode, so every JALR redirects.
  assign mispredict   = fire & ((is_branch & (br_taken != D_BranchTaken)) | is_jalr);

  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;
    out_valid_d      = out_valid_q;
    out_pc_d         = out_pc_q;
    out_link_d       = out_link_q;
    out_taken_d      = out_taken_q;
    branch_cnt_d     = branch_cnt_q;
    mispred_cnt_d    = mispred_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (mispredict) begin
          state_d          = ST_REDIRECT;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = is_jalr ? jalr_target : D_recoverPC;
          flush_d          = 1'b1;
          mispred_cnt_d    = mispred_cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_REDIRECT: begin
        if (redirect_ack) begin
          state_d          = ST_IDLE;
          redirect_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fire) begin
      out_valid_d = 1'b1;
      out_pc_d    = D_PC;
      out_link_d  = link_pc;
      out_taken_d = actual_taken;
      if (is_branch) begin
        branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      out_valid_q      <= 1'b0;
      out_pc_q         <= '0;
      out_link_q       <= '0;
      out_taken_q      <= 1'b0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      out_valid_q      <= out_valid_d;
      out_pc_q         <= out_pc_d;
      out_link_q       <= out_link_d;
      out_taken_q      <= out_taken_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign out_link       = out_link_q;
  assign out_taken      = out_taken_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Bench for ex_branch_resolve (CNT_WIDTH=4 so counter wrap is reachable):
// directed scenarios, then random traffic against a transaction-level model.
module tb_ex_branch_resolve;
  import ex_branch_resolve_pkg::*;

  localparam int XLEN = 32;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            D_instr_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     D_PC = '0, D_recoverPC = '0, D_immediate32 = '0;
  logic [7:0]      D_instr_type = '0;
  logic [2:0]      D_funct3 = '0;
  logic            D_BranchTaken = 1'b0;
  logic [31:0]     rs1_data = '0, rs2_data = '0;
  logic            redirect_valid, flush, out_valid, out_taken;
  logic [31:0]     redirect_pc, out_pc, out_link;
  logic            redirect_ack = 1'b0;
  logic            out_ready = 1'b1;
  logic [CW-1:0]   branch_cnt, mispred_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_branch_resolve #(.XLEN(XLEN), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .D_instr_valid(D_instr_valid), .in_ready(in_ready),
    .D_PC(D_PC), .D_recoverPC(D_recoverPC), .D_instr_type(D_instr_type),
    .D_funct3(D_funct3), .D_immediate32(D_immediate32), .D_BranchTaken(D_BranchTaken),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ack(redirect_ack), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_link(out_link),
    .out_taken(out_taken), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  function automatic bit ref_cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa = a;
    int sb = b;
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_instr(input logic [7:0] typ, input logic [2:0] f3, input logic [31:0] pc,
                             input logic [31:0] rpc, input logic [31:0] imm, input logic [31:0] a,
                             input logic [31:0] b, input logic pt);
    D_instr_valid = 1'b1; D_instr_type = typ; D_funct3 = f3; D_PC = pc; D_recoverPC = rpc;
    D_immediate32 = imm; rs1_data = a; rs2_data = b; D_BranchTaken = pt;
  endtask

  task automatic idle_inputs;
    D_instr_valid = 1'b0; D_instr_type = '0;
  endtask

  task automatic test_reset;
    #3 rst = 1'b0;
    #1;
    n_cmp++; if ({redirect_valid, flush, out_valid, out_taken} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_flags got %b want 0000", {redirect_valid, flush, out_valid, out_taken}); end
    n_cmp++; if (redirect_pc !== 0 || out_pc !== 0 || out_link !== 0) begin n_fail++;
      $display("FAIL reset_data got rpc=%h pc=%h link=%h want 0", redirect_pc, out_pc, out_link); end
    n_cmp++; if (branch_cnt !== 0 || mispred_cnt !== 0) begin n_fail++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", branch_cnt, mispred_cnt); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_idle got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_beq;
    drive_instr(OH_BRANCH, F3_BEQ, 32'h100, 32'h104, 32'h20, 32'd5, 32'd5, 1'b1);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL beq_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1; idle_inputs();
    n_cmp++; if ({out_valid, out_taken, redirect_valid, flush} !== 4'b1100) begin n_fail++;
      $display("FAIL beq_flags got %b want 1100", {out_valid, out_taken, redirect_valid, flush}); end
    n_cmp++; if (out_pc !== 32'h100 || out_link !== 32'h104) begin n_fail++;
      $display("FAIL beq_result got pc=%h link=%h want 100/104", out_pc, out_link); end
    n_cmp++; if (branch_cnt !== 4'd1 || mispred_cnt !== 4'd0) begin n_fail++;
      $display("FAIL beq_cnt got %0d/%0d want 1/0", branch_cnt, mispred_cnt); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL beq_drain got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_blt_mispredict;
    drive_instr(OH_BRANCH, F3_BLT, 32'h200, 32'h240, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b0);
    @(posedge clk); #1; idle_inputs();
    n_cmp++; if ({redirect_valid, flush, out_valid, out_taken, in_ready} !== 5'b11110) begin n_fail++;
      $display("FAIL blt_flags got %b want 11110", {redirect_valid, flush, out_valid, out_taken, in_ready}); end
    n_cmp++; if (redirect_pc !== 32'h240) begin n_fail++; $display("FAIL blt_rpc got %h want 240", redirect_pc); end
    n_cmp++; if (branch_cnt !== 4'd2 || mispred_cnt !== 4'd1) begin n_fail++;
      $display("FAIL blt_cnt got %0d/%0d want 2/1", branch_cnt, mispred_cnt); end
    @(posedge clk); #1;
    n_cmp++; if ({redirect_valid, flush, in_ready} !== 3'b100) begin n_fail++;
      $display("FAIL blt_hold got %b want 100", {redirect_valid, flush, in_ready}); end
    redirect_ack = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL blt_ack_cycle got in_ready=%b want 0", in_ready); end
    @(posedge clk); #1; redirect_ack = 1'b0;
    n_cmp++; if ({redirect_valid, in_ready} !== 2'b01) begin n_fail++;
      $display("FAIL blt_release got %b want 01", {redirect_valid, in_ready}); end
  endtask

  task automatic test_bltu_mispredict;
    drive_instr(OH_BRANCH, F3_BLTU, 32'h200, 32'h204, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1);
    @(posedge clk); #1; idle_inputs();
    n_cmp++; if ({redirect_valid, flush, out_valid, out_taken} !== 4'b1110 || redirect_pc !== 32'h204) begin n_fail++;
      $display("FAIL bltu got flags=%b rpc=%h want 1110/204", {redirect_valid, flush, out_valid, out_taken}, redirect_pc); end
    n_cmp++; if (branch_cnt !== 4'd3 || mispred_cnt !== 4'd2) begin n_fail++;
      $display("FAIL bltu_cnt got %0d/%0d want 3/2", branch_cnt, mispred_cnt); end
    redirect_ack = 1'b1;
    @(posedge clk); #1; redirect_ack = 1'b0;
    n_cmp++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bltu_release got %b want 0", redirect_valid); end
  endtask

  task automatic test_jalr;
    drive_instr(OH_JALR, 3'd0, 32'h300, 32'hDEAD_0000, 32'd4, 32'h1001, 32'd0, 1'b0);
    @(posedge clk); #1; idle_inputs();
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1004) begin n_fail++;
      $display("FAIL jalr_rpc got v=%b pc=%h want 1/1004", redirect_valid, redirect_pc); end
    n_cmp++; if (out_link !== 32'h304 || out_taken !== 1'b1 || out_pc !== 32'h300) begin n_fail++;
      $display("FAIL jalr_result got link=%h taken=%b pc=%h want 304/1/300", out_link, out_taken, out_pc); end
    n_cmp++; if (branch_cnt !== 4'd3 || mispred_cnt !== 4'd3) begin n_fail++;
      $display("FAIL jalr_cnt got %0d/%0d want 3/3", branch_cnt, mispred_cnt); end
    redirect_ack = 1'b1;
    @(posedge clk); #1; redirect_ack = 1'b0;
  endtask

  task automatic test_hold_then_reset;
    out_ready = 1'b0;
    drive_instr(OH_JALR, 3'd0, 32'h400, 32'h0, 32'h10, 32'h2000, 32'd0, 1'b1);
    @(posedge clk); #1; idle_inputs();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({redirect_valid, out_valid, in_ready} !== 3'b110 || redirect_pc !== 32'h2010 ||
          out_pc !== 32'h400 || out_link !== 32'h404) begin
        n_fail++;
        $display("FAIL hold_%0d got flags=%b rpc=%h pc=%h link=%h want 110/2010/400/404",
                 i, {redirect_valid, out_valid, in_ready}, redirect_pc, out_pc, out_link);
      end
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({redirect_valid, flush, out_valid, out_taken, in_ready} !== 5'b00001) begin n_fail++;
      $display("FAIL midreset_flags got %b want 00001", {redirect_valid, flush, out_valid, out_taken, in_ready}); end
    n_cmp++; if (redirect_pc !== 0 || out_pc !== 0 || out_link !== 0 || branch_cnt !== 0 || mispred_cnt !== 0) begin
      n_fail++; $display("FAIL midreset_data got rpc=%h pc=%h link=%h cnt=%0d/%0d want zeros",
                         redirect_pc, out_pc, out_link, branch_cnt, mispred_cnt); end
    out_ready = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_counter_wrap;
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      drive_instr(OH_BRANCH, F3_BEQ, 32'h1000 + 32'(i * 4), 32'h0, 32'h40, v, v, 1'b1);
      @(posedge clk); #1;
      if (i == 14) begin
        n_cmp++; if (branch_cnt !== 4'd15) begin n_fail++; $display("FAIL wrap_pre got %0d want 15", branch_cnt); end
      end
    end
    idle_inputs();
    n_cmp++; if (branch_cnt !== 4'd0 || mispred_cnt !== 4'd0) begin n_fail++;
      $display("FAIL wrap got %0d/%0d want 0/0", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_random;
    bit e_rv = 0, e_fl = 0, e_ov = 0, e_tk = 0, exp_rdy, fire, is_b, is_jal, is_jalr, act, mis;
    logic [31:0] e_rpc = '0, e_pc = '0, e_link = '0;
    int e_bc = 0, e_mc = 0;
    int r;
    @(negedge clk); rst = 1'b0; idle_inputs(); redirect_ack = 1'b0; out_ready = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_cmp++; if ({redirect_valid, flush, out_valid} !== {e_rv, e_fl, e_ov}) begin n_fail++;
        $display("FAIL rnd_flags c%0d got %b want %b", cyc, {redirect_valid, flush, out_valid}, {e_rv, e_fl, e_ov}); end
      if (e_rv) begin
        n_cmp++; if (redirect_pc !== e_rpc) begin n_fail++;
          $display("FAIL rnd_rpc c%0d got %h want %h", cyc, redirect_pc, e_rpc); end
      end
      if (e_ov) begin
        n_cmp++; if (out_pc !== e_pc || out_link !== e_link || out_taken !== e_tk) begin n_fail++;
          $display("FAIL rnd_out c%0d got %h/%h/%b want %h/%h/%b", cyc, out_pc, out_link, out_taken, e_pc, e_link, e_tk); end
      end
      n_cmp++; if (branch_cnt !== CW'(e_bc) || mispred_cnt !== CW'(e_mc)) begin n_fail++;
        $display("FAIL rnd_cnt c%0d got %0d/%0d want %0d/%0d", cyc, branch_cnt, mispred_cnt, e_bc, e_mc); end

      out_ready    = ($urandom % 4) != 0;
      redirect_ack = ($urandom % 3) == 0;
      r = $urandom % 5;
      drive_instr(r == 0 ? OH_BRANCH : r == 1 ? OH_JAL : r == 2 ? OH_JALR : r == 3 ? 8'h01 : 8'h00,
                  3'($urandom), {$urandom} & 32'hFFFF_FFFC, $urandom, $urandom, $urandom, $urandom, 1'($urandom));
      if ($urandom % 3 == 0) rs2_data = rs1_data;
      D_instr_valid = ($urandom % 4) != 0;
      if (!D_instr_valid) D_instr_type = '0;
      #1;
      exp_rdy = !e_rv && (!e_ov || out_ready);
      n_cmp++; if (in_ready !== exp_rdy) begin n_fail++;
        $display("FAIL rnd_in_ready c%0d got %b want %b", cyc, in_ready, exp_rdy); end

      fire    = exp_rdy && D_instr_valid;
      is_b    = D_instr_type == OH_BRANCH;
      is_jal  = D_instr_type == OH_JAL;
      is_jalr = D_instr_type == OH_JALR;
      act     = is_b ? ref_cond(D_funct3, rs1_data, rs2_data) : (is_jal || is_jalr);
      mis     = is_jalr || (is_b && act != D_BranchTaken);
      e_fl    = 0;
      if (e_rv && redirect_ack) e_rv = 0;
      if (fire) begin
        e_ov = 1; e_pc = D_PC; e_link = D_PC + 32'd4; e_tk = act;
        if (is_b) e_bc = (e_bc + 1) % 16;
        if (mis) begin
          e_rv = 1; e_fl = 1; e_mc = (e_mc + 1) % 16;
          e_rpc = is_jalr ? ((rs1_data + D_immediate32) & 32'hFFFF_FFFE) : D_recoverPC;
        end
      end else if (out_ready) begin
        e_ov = 0;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_beq();
    test_blt_mispredict();
    test_bltu_mispredict();
    test_jalr();
    test_hold_then_reset();
    test_counter_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
